// File: rtl/bellman_relax.sv
// bellman_relax: Bellman-Ford relaxation engine feeding the negative-cycle detector.
// Define RELAX_STATS_EN to enable the stat_relax_cnt / stat_pass_cnt counters.
module bellman_relax #(
    parameter int NODES    = 32,
    parameter int PRED_W   = 5,
    parameter int WEIGHT_W = 32
) (
    input  logic                       clk,
    input  logic                       relax_reset_n,
    input  logic                       relax_start,
    output logic [PRED_W-1:0]          adjmat_row_addr,
    output logic [PRED_W-1:0]          adjmat_col_addr,
    input  logic [WEIGHT_W-1:0]        adjmat_q,
    output logic [PRED_W-1:0]          vertmat_addr_a,
    input  logic [PRED_W+WEIGHT_W-1:0] vertmat_q_a,
    output logic [PRED_W-1:0]          vertmat_addr_b,
    input  logic [PRED_W+WEIGHT_W-1:0] vertmat_q_b,
    output logic [PRED_W+WEIGHT_W-1:0] vertmat_data_b,
    output logic                       vertmat_we_b,
    output logic                       relax_busy,
    output logic                       relax_done,
    output logic                       relax_converged,
    output logic                       cycle_reset,
    output logic [15:0]                stat_relax_cnt,
    output logic [PRED_W:0]            stat_pass_cnt
);
    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_RD, S_WAIT, S_CHECK, S_WR, S_NEXT, S_PASS_END, S_DONE
    } state_t;
    localparam logic [PRED_W-1:0] LAST      = PRED_W'(NODES - 1);
    localparam logic [PRED_W:0]   PASS_LAST = (PRED_W + 1)'(NODES - 1);
    state_t                   r_state, w_next;
    logic [PRED_W-1:0]        r_v, r_i, r_j;
    logic [PRED_W:0]          r_pass, w_pass_inc;
    logic                     r_changed, r_conv, r_cyc;
    logic [WEIGHT_W-1:0]      r_sat, w_sat;
    logic signed [WEIGHT_W:0] w_sum, w_dst;
    logic                     w_improve, w_accept, w_unused;
    // Sums carry one guard bit so overflow is detected and clamped, never wrapped.
    assign w_sum      = $signed({vertmat_q_a[WEIGHT_W-1], vertmat_q_a[WEIGHT_W-1:0]})
                      + $signed({adjmat_q[WEIGHT_W-1], adjmat_q});
    assign w_dst      = $signed({vertmat_q_b[WEIGHT_W-1], vertmat_q_b[WEIGHT_W-1:0]});
    assign w_improve  = (adjmat_q != '0) && (w_sum < w_dst);
    assign w_sat      = (w_sum[WEIGHT_W] != w_sum[WEIGHT_W-1])
                      ? {w_sum[WEIGHT_W], {(WEIGHT_W-1){~w_sum[WEIGHT_W]}}}
                      : w_sum[WEIGHT_W-1:0];
    assign w_pass_inc = r_pass + 1'b1;
    assign w_accept   = relax_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_unused   = ^{vertmat_q_a[PRED_W+WEIGHT_W-1:WEIGHT_W], vertmat_q_b[PRED_W+WEIGHT_W-1:WEIGHT_W]};
    always_ff @(posedge clk or negedge relax_reset_n) begin
        if (!relax_reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = relax_start ? S_INIT : r_state;
            S_INIT:         w_next = (r_v == LAST) ? S_RD : S_INIT;
            S_RD:           w_next = S_WAIT;
            S_WAIT:         w_next = S_CHECK;
            S_CHECK:        w_next = w_improve ? S_WR : S_NEXT;
            S_WR:           w_next = S_NEXT;
            S_NEXT:         w_next = (r_i == LAST && r_j == LAST) ? S_PASS_END : S_RD;
            S_PASS_END:     w_next = (!r_changed || w_pass_inc == PASS_LAST) ? S_DONE : S_RD;
            default:        w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge relax_reset_n) begin
        if (!relax_reset_n) begin
            r_v       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_pass    <= '0;
            r_changed <= 1'b0;
            r_conv    <= 1'b0;
            r_cyc     <= 1'b0;
            r_sat     <= '0;
        end else begin
            r_cyc <= 1'b0;
            if (w_accept) begin
                r_v       <= '0;
                r_i       <= '0;
                r_j       <= '0;
                r_pass    <= '0;
                r_changed <= 1'b0;
                r_conv    <= 1'b0;
            end
            case (r_state)
                S_INIT:  r_v <= r_v + 1'b1;
                S_CHECK: r_sat <= w_sat;
                S_WR:    r_changed <= 1'b1;
                S_NEXT: begin
                    r_j <= (r_j == LAST) ? '0 : r_j + 1'b1;
                    if (r_j == LAST)
                        r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
                end
                S_PASS_END: begin
                    r_pass    <= w_pass_inc;
                    r_changed <= 1'b0;
                    if (w_next == S_DONE) begin
                        r_cyc  <= 1'b1;
                        r_conv <= !r_changed;
                    end
                end
                default: ;
            endcase
        end
    end
    assign adjmat_row_addr = r_i;
    assign adjmat_col_addr = r_j;
    assign vertmat_addr_a  = r_i;
    assign vertmat_addr_b  = (r_state == S_INIT) ? r_v : r_j;
    assign vertmat_we_b    = (r_state == S_INIT) || (r_state == S_WR);
    assign vertmat_data_b  = (r_state == S_INIT) ? {r_v, {WEIGHT_W{1'b0}}}
                           : (r_state == S_WR)   ? {r_i, r_sat} : '0;
    assign relax_busy      = !(r_state == S_IDLE || r_state == S_DONE);
    assign relax_done      = (r_state == S_DONE);
    assign relax_converged = r_conv;
    assign cycle_reset     = r_cyc;
`ifdef RELAX_STATS_EN
    logic [15:0] r_relax_cnt;
    always_ff @(posedge clk or negedge relax_reset_n) begin
        if (!relax_reset_n)
            r_relax_cnt <= '0;
        else if (w_accept)
            r_relax_cnt <= '0;
        else if (r_state == S_WR && r_relax_cnt != 16'hFFFF)
            r_relax_cnt <= r_relax_cnt + 1'b1;
    end
    assign stat_relax_cnt = r_relax_cnt;
    assign stat_pass_cnt  = r_pass;
`else
    assign stat_relax_cnt = '0;
    assign stat_pass_cnt  = '0;
`endif
endmodule

// File: tb/tb_bellman_relax.sv
// tb_bellman_relax: directed table plus random graphs for bellman_relax (NODES=4),
// checked against a plain Bellman-Ford model with saturating distances.
module tb_bellman_relax;
    localparam int N    = 4;
    localparam int PW   = 2;
    localparam int WW   = 32;
    localparam int ETOT = 4 * N * N + 1;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic              rst_n, start;
    logic [PW-1:0]     row, col, addr_a, addr_b;
    logic [WW-1:0]     adj_q;
    logic [PW+WW-1:0]  qa, qb, data_b;
    logic              we_b, busy, done, conv, cyc_rst;
    logic [15:0]       stat_relax;
    logic [PW:0]       stat_pass;
    bellman_relax #(.NODES(N), .PRED_W(PW), .WEIGHT_W(WW)) dut (
        .clk(clk), .relax_reset_n(rst_n), .relax_start(start),
        .adjmat_row_addr(row), .adjmat_col_addr(col), .adjmat_q(adj_q),
        .vertmat_addr_a(addr_a), .vertmat_q_a(qa),
        .vertmat_addr_b(addr_b), .vertmat_q_b(qb),
        .vertmat_data_b(data_b), .vertmat_we_b(we_b),
        .relax_busy(busy), .relax_done(done), .relax_converged(conv),
        .cycle_reset(cyc_rst), .stat_relax_cnt(stat_relax), .stat_pass_cnt(stat_pass)
    );
    logic signed [WW-1:0] adj [N][N];
    logic [PW+WW-1:0]     vm [N];
    always @(posedge clk) begin
        adj_q <= adj[row][col];
        qa    <= vm[addr_a];
        qb    <= vm[addr_b];
        if (we_b) vm[addr_b] <= data_b;
    end
    int n_we = 0, n_cr = 0, n_bad = 0;
    always @(negedge clk) begin
        if (we_b) n_we++;
        if (cyc_rst) n_cr++;
        if (!we_b && data_b !== '0) n_bad++;
    end
    int n_chk = 0, n_err = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    logic signed [WW-1:0] m_d [N];
    logic [PW-1:0]        m_p [N];
    int                   m_writes, m_passes;
    bit                   m_conv;
    task automatic model();
        longint d [N];
        longint s;
        bit ch;
        for (int v = 0; v < N; v++) begin
            d[v] = 0;
            m_p[v] = PW'(v);
        end
        m_writes = 0;
        m_passes = 0;
        do begin
            ch = 0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (adj[i][j] != 0) begin
                        s = d[i] + longint'(adj[i][j]);
                        if (s < d[j]) begin
                            d[j] = (s < -64'sd2147483648) ? -64'sd2147483648 : (s > 64'sd2147483647) ? 64'sd2147483647 : s;
                            m_p[j] = PW'(i);
                            ch = 1;
                            m_writes++;
                        end
                    end
            m_passes++;
        end while (ch && m_passes < N - 1);
        m_conv = !ch;
        for (int v = 0; v < N; v++) m_d[v] = WW'(d[v]);
    endtask
    typedef struct {
        logic signed [WW-1:0] w [N*N];
        bit                   conv;
        int                   wr;
        int                   ps;
    } vec_t;
    vec_t tbl [4];
    task automatic load(input logic signed [WW-1:0] w [N*N]);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                adj[i][j] = w[i*N+j];
    endtask
    task automatic run(input string nm, input int g, input bit e_conv, input int e_wr, input int e_ps);
        int cyc, w0, c0, b0;
        w0 = n_we;
        c0 = n_cr;
        b0 = n_bad;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({nm, " start accepted"}, {done, busy}, 2'b01);
        cyc = 0;
        while (busy && cyc < 20000) begin
            start = (g >= 0 && cyc >= g && cyc < g + 5);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({nm, " done"}, {done, cyc_rst, conv}, {2'b11, e_conv});
        @(negedge clk);
        chk({nm, " cycle_reset width"}, {cyc_rst, done}, 2'b01);
        chk({nm, " cycles"}, cyc, N + e_ps * ETOT + e_wr);
        chk({nm, " writes"}, n_we - w0, N + e_wr);
        chk({nm, " cycle_reset pulses"}, n_cr - c0, 1);
        chk({nm, " idle data_b"}, n_bad - b0, 0);
        for (int v = 0; v < N; v++)
            chk($sformatf("%s vert%0d", nm, v), vm[v], {m_p[v], m_d[v]});
`ifdef RELAX_STATS_EN
        chk({nm, " stat_relax"}, stat_relax, (e_wr > 65535) ? 65535 : e_wr);
        chk({nm, " stat_pass"}, stat_pass, e_ps);
`else
        chk({nm, " stat tied"}, {stat_relax, stat_pass}, 0);
`endif
    endtask
    initial begin
        int k, cyc, r;
        longint a, b;
        for (int t = 0; t < 4; t++)
            for (int e = 0; e < N * N; e++) tbl[t].w[e] = '0;
        tbl[0].w[0*N+1] = -5;
        tbl[0].conv = 1; tbl[0].wr = 1; tbl[0].ps = 2;
        tbl[1].conv = 1; tbl[1].wr = 0; tbl[1].ps = 1;
        tbl[2].w[0*N+1] = -3; tbl[2].w[1*N+2] = -3; tbl[2].w[2*N+0] = -3;
        tbl[2].conv = 0; tbl[2].wr = 9; tbl[2].ps = 3;
        tbl[3].w[0*N+1] = -1; tbl[3].w[1*N+2] = 32'h80000000;
        tbl[3].conv = 0; tbl[3].wr = 4; tbl[3].ps = 3;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset status", {busy, done, conv, cyc_rst, we_b}, 0);
        chk("reset addresses", {row, col, addr_a, addr_b}, 0);
        chk("reset data_b", data_b, 0);
        chk("reset stats", {stat_relax, stat_pass}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle after reset", {busy, done}, 2'b00);
        for (int t = 0; t < 4; t++) begin
            load(tbl[t].w);
            model();
            run($sformatf("vec%0d", t), -1, tbl[t].conv, tbl[t].wr, tbl[t].ps);
            if (t == 2) begin
                a = longint'($signed(vm[0][WW-1:0]));
                b = longint'($signed(vm[1][WW-1:0]));
                chk("cycle vert0 pred", vm[0][PW+WW-1:WW], 2);
                chk("cycle edge 0->1 still improves", (a - 3) < b, 1);
            end
            if (t == 3) chk("saturated vert2", vm[2], {2'd1, 32'h80000000});
        end
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    r = int'($urandom_range(0, 19));
                    adj[i][j] = (r < 8) ? 0 : (r == 8) ? 32'h80000000 : (r == 9) ? 32'h7fffffff
                              : WW'(int'($urandom_range(0, 40)) - 12);
                end
            model();
            run($sformatf("rand%0d", t), -1, m_conv, m_writes, m_passes);
        end
        load(tbl[0].w);
        model();
        run("start during busy", 10, 1, 1, 2);
        load(tbl[2].w);
        model();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        cyc = 0;
        while (cyc < 2000) begin
            if (we_b) k++;
            if (k == N + 4) break;
            @(negedge clk);
            cyc++;
        end
        chk("reached pass-2 write", k, N + 4);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset mid-WR", {we_b, busy, done}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        run("after reset", -1, 0, 9, 3);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
